// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: FSM state encoding, frame size, command bytes and
// the odd-parity helper used when loading a host-to-device frame.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    INHIBIT   = 3'd1,
    RTS       = 3'd2,
    SHIFT     = 3'd3,
    ACK       = 3'd4,
    WAIT_IDLE = 3'd5
  } ps2_state_e;

  // start + 8 data + parity + stop
  localparam int PS2_FRAME_BITS = 11;

  localparam logic [7:0] CMD_SET_LED = 8'hED;
  localparam logic [7:0] CMD_RESET   = 8'hFF;
  localparam logic [7:0] RESP_ACK    = 8'hFA;

  // PS/2 parity is odd: the parity bit makes the 9-bit total count odd
  function automatic logic odd_parity(input logic [7:0] b);
    return ~^b;
  endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// Two-flop synchronizer plus falling-edge detect for one raw PS/2 line.
// Flops reset to 1 (idle bus level) so reset never produces a spurious fall.
module ps2_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic line,
  output logic sync,
  output logic fall
);

  logic s1, s2, prev;

  // synchronize the asynchronous line and keep the previous synced value
  always_ff @(posedge clk) begin
    if (rst) begin
      s1   <= 1'b1;
      s2   <= 1'b1;
      prev <= 1'b1;
    end else begin
      s1   <= line;
      s2   <= s1;
      prev <= s2;
    end
  end

  assign sync = s2;
  assign fall = prev & ~s2;

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibits the bus, issues request-to-send,
// shifts data/parity/stop out on device clock falls and samples the ACK.
// Both lines are driven open-drain through registered low-enables.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int CNT_W          = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       busy,
  output logic       tx_done,
  output logic       tx_ack_ok,
  output logic       tx_error
);

  localparam logic [CNT_W-1:0] INH_LAST  = CNT_W'(INHIBIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);
  // bit_cnt value on the fall that drives the stop bit (fall 10)
  localparam logic [3:0]       LAST_SHIFT = 4'(PS2_FRAME_BITS - 2);

  ps2_state_e       state;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       bit_cnt;
  logic [9:0]       shreg;
  logic             clk_oe_r, data_oe_r;
  logic             done_r, ack_ok_r, err_r, ack_smp;

  logic clk_sync, clk_fall, data_sync, data_fall;

  ps2_sync_edge u_clk_se (
    .clk  (clk),
    .rst  (rst),
    .line (ps2_clk_in),
    .sync (clk_sync),
    .fall (clk_fall)
  );

  ps2_sync_edge u_data_se (
    .clk  (clk),
    .rst  (rst),
    .line (ps2_data_in),
    .sync (data_sync),
    .fall (data_fall)
  );

  logic timeout;
  // the timeout window covers everything after the inhibit phase
  assign timeout = (state inside {RTS, SHIFT, ACK, WAIT_IDLE}) && (cnt == TO_LAST);

  // frame sequencer; timeout wins over a fall arriving in the same cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      bit_cnt   <= '0;
      shreg     <= '0;
      clk_oe_r  <= 1'b0;
      data_oe_r <= 1'b0;
      done_r    <= 1'b0;
      ack_ok_r  <= 1'b0;
      err_r     <= 1'b0;
      ack_smp   <= 1'b0;
    end else begin
      done_r <= 1'b0;
      if (timeout) begin
        clk_oe_r  <= 1'b0;
        data_oe_r <= 1'b0;
        done_r    <= 1'b1;
        err_r     <= 1'b1;
        ack_ok_r  <= 1'b0;
        cnt       <= '0;
        state     <= IDLE;
      end else begin
        unique case (state)
          IDLE: begin
            if (tx_valid) begin
              shreg     <= {1'b1, odd_parity(tx_data), tx_data};
              cnt       <= '0;
              bit_cnt   <= '0;
              clk_oe_r  <= 1'b1;
              data_oe_r <= 1'b0;
              state     <= INHIBIT;
            end
          end
          INHIBIT: begin
            if (cnt == INH_LAST) begin
              cnt       <= '0;
              data_oe_r <= 1'b1;   // start bit, clock still held low
              state     <= RTS;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          RTS: begin
            clk_oe_r <= 1'b0;      // hand the clock to the device
            cnt      <= '0;
            state    <= SHIFT;
          end
          SHIFT: begin
            cnt <= cnt + 1'b1;
            if (clk_fall) begin
              data_oe_r <= ~shreg[0];
              shreg     <= {1'b0, shreg[9:1]};
              bit_cnt   <= bit_cnt + 1'b1;
              if (bit_cnt == LAST_SHIFT) state <= ACK;
            end
          end
          ACK: begin
            cnt <= cnt + 1'b1;
            if (clk_fall) begin
              ack_smp <= ~data_sync;
              state   <= WAIT_IDLE;
            end
          end
          WAIT_IDLE: begin
            cnt <= cnt + 1'b1;
            if (clk_sync && data_sync) begin
              done_r   <= 1'b1;
              ack_ok_r <= ack_smp;
              err_r    <= 1'b0;
              cnt      <= '0;
              state    <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  // data_fall is not needed by the transmitter; the receiver side uses it
  logic unused_data_fall;
  assign unused_data_fall = data_fall;

  assign tx_ready    = (state == IDLE);
  assign busy        = (state != IDLE);
  assign ps2_clk_oe  = clk_oe_r;
  assign ps2_data_oe = data_oe_r;
  assign tx_done     = done_r;
  assign tx_ack_ok   = ack_ok_r;
  assign tx_error    = err_r;

endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
- Host-to-device PS/2 transmitter. It sends one command byte (e.g. 0xED set-LEDs, 0xFF reset) to the keyboard over the same ps2_clk/ps2_data lines the keyboard receiver listens on.
- It drives both lines open-drain through low-enables. It inhibits the bus, issues a request-to-send, and shifts out data, parity and stop bits on device-generated clock edges. It then samples the device ACK.
- busy lets the receiver side ignore bus activity during a host transmission.

Parameters:
- INHIBIT_CYCLES, 5000, clk cycles to hold ps2_clk low before request-to-send (100 us at 50 MHz).
- TIMEOUT_CYCLES, 1000000, max clk cycles from end of inhibit to frame completion (20 ms at 50 MHz).
- CNT_W, 20, width of the shared cycle counter; must hold max(INHIBIT_CYCLES, TIMEOUT_CYCLES).

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous reset, active-high
- tx_valid  input  1  request to send tx_data
- tx_data  input  8  command byte
- tx_ready  output  1  high only in IDLE; a byte is accepted when tx_valid & tx_ready
- ps2_clk_in  input  1  raw PS/2 clock line level (asynchronous)
- ps2_data_in  input  1  raw PS/2 data line level (asynchronous)
- ps2_clk_oe  output  1  1 = pull ps2_clk low, 0 = release
- ps2_data_oe  output  1  1 = pull ps2_data low, 0 = release
- busy  output  1  high in any state other than IDLE
- tx_done  output  1  one-cycle pulse at frame end (success, NACK or timeout)
- tx_ack_ok  output  1  valid with tx_done: device ACKed (data low on 11th edge)
- tx_error  output  1  valid with tx_done: timeout abort

Behaviour:
- Reset values: tx_ready=1, busy=0, ps2_clk_oe=0, ps2_data_oe=0, tx_done=0, tx_ack_ok=0, tx_error=0, state=IDLE, counters=0.
- rst asserted mid-frame releases both lines on the next clk edge; no tx_done is issued.
- Inputs pass through a 2-flop synchronizer plus a previous-value register.
  - fall = prev & ~sync.
  - Data is sampled from the synchronized value.
  - Latency is 3 clk cycles from line to fall.
- IDLE:
  - On tx_valid & tx_ready, latch tx_data and compute parity = ~^tx_data (odd parity).
  - Load shift register {1'b1 stop, parity, data[7:0]}, LSB first.
  - Go to INHIBIT. tx_valid while busy is ignored.
- INHIBIT:
  - ps2_clk_oe=1, data released.
  - After INHIBIT_CYCLES cycles, go to RTS.
- RTS:
  - ps2_data_oe=1 (start bit 0) for exactly 1 cycle with ps2_clk_oe still 1.
  - Then release ps2_clk_oe, clear the counter and go to SHIFT. The timeout counter runs from here.
- SHIFT:
  - On each fall, drive the next shift-register bit: ps2_data_oe = ~bit. Increment bit_cnt (0..9).
  - Falls 1-8 drive data bits d0..d7, fall 9 drives parity, fall 10 drives stop (line released).
  - After fall 10, go to ACK.
- ACK:
  - On fall 11, sample synchronized data. tx_ack_ok_r = ~data.
  - Go to WAIT_IDLE.
- WAIT_IDLE:
  - Wait until synchronized clk=1 and data=1.
  - Then pulse tx_done with tx_ack_ok and return to IDLE. tx_ready is high the cycle after tx_done.
- Timeout: in RTS/SHIFT/ACK/WAIT_IDLE, counter reaching TIMEOUT_CYCLES releases both lines.
  - It pulses tx_done with tx_error=1, tx_ack_ok=0, and goes to IDLE.
  - Timeout takes priority over a simultaneous fall.
- tx_ack_ok and tx_error hold their values until the next tx_done; only tx_done is a pulse.
- The two oe outputs are registered; they are never both released while in INHIBIT.

Decomposition:
- Package ps2_pkg:
  - State enum {IDLE, INHIBIT, RTS, SHIFT, ACK, WAIT_IDLE}.
  - Localparam PS2_FRAME_BITS=11.
  - Command constants CMD_SET_LED=8'hED, CMD_RESET=8'hFF, RESP_ACK=8'hFA.
- Sub-module ps2_sync_edge: 2-flop synchronizer plus falling-edge detect for one line, instantiated for clk and data.
  - The receiver may reuse it.

Test Plan:
- Send 0xED with a device model clocking at ~12 kHz and ACKing -> ps2_data_oe sequence after RTS shows bits 1,0,1,1,0,1,1,1, parity 1, stop released. tx_done pulses with tx_ack_ok=1, tx_error=0.
- Send 0x01 -> parity bit 0. Send 0x00 and 0xFF -> parity bit 1 in both cases; frame otherwise correct.
- Check ps2_clk_oe is high for exactly INHIBIT_CYCLES cycles, then data_oe=1 before clk_oe drops -> checked with INHIBIT_CYCLES=16 override.
- Device never clocks, with TIMEOUT_CYCLES=200 -> tx_done plus tx_error=1 exactly 200 cycles after RTS, both oe=0, tx_ready=1 on the next cycle.
- Device leaves data high on the 11th edge -> tx_done with tx_ack_ok=0, tx_error=0.
- Assert rst during SHIFT after bit 4, and tx_valid while busy -> both oe=0 the next cycle with no tx_done. The busy-time tx_valid is not accepted, and after reset a new 0xFF sends cleanly.
